program_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of the processor. It accepts a framed byte stream over a valid/ready handshake, assembles 13-bit instruction words, and writes them sequentially into the processor's instruction memory through the `instr_out`/`instr_addr` load port. It holds the processor in reset for the whole load and releases it only after a complete, well-formed program has been written.

---
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory load port.
// The loader side uses the master modport (it drives in_ready and the
// memory write port); the stream source / memory side uses slave.
interface program_loader_if #(
  parameter int INSTR_W = 13,
  parameter int ADDR_W  = 4
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_we;

  modport master (
    input  in_data, in_valid,
    output in_ready, instr_out, instr_addr, instr_we
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, instr_out, instr_addr, instr_we
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (header N, then N x {lo, hi}
// instruction bytes), writes the assembled words into instruction memory at
// addresses 0..N-1 and holds the processor in reset until a well-formed
// program has been fully written.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte (8-bit sum of header and data bytes) before release.
module program_loader #(
  parameter int INSTR_W = 13,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_reset,
  output logic             done,
  output logic             error
);

  // Counter is one bit wider than the address so it can hold N = DEPTH.
  localparam int         CW      = ADDR_W + 1;
  localparam int         HW      = INSTR_W - 8;
  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_WRITE, S_DONE, S_ERROR
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      lo_q;
  logic            xfer;
  logic            start_go;
  logic            hdr_bad;
  logic            hi_bad;
  logic            last_word;
  logic            rx_next;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q;
  logic            ck_ok;
  assign ck_ok = (bus.in_data == sum_q);
`endif

  assign xfer      = bus.in_valid && bus.in_ready;
  assign start_go  = start && (state_q == S_IDLE || state_q == S_DONE ||
                               state_q == S_ERROR);
  assign hdr_bad   = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > DEPTH_B);
  assign hi_bad    = |bus.in_data[7:HW];
  assign last_word = ((cnt_q + CW'(1)) == n_q);

  // Next-state logic; byte-receiving states only advance on a transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_HDR;
      S_HDR:   if (xfer) state_d = hdr_bad ? S_ERROR : S_LO;
      S_LO:    if (xfer) state_d = S_HI;
      S_HI:    if (xfer) state_d = hi_bad ? S_ERROR : S_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_WRITE: state_d = last_word ? S_CHK : S_LO;
      S_CHK:   if (xfer) state_d = ck_ok ? S_DONE : S_ERROR;
`else
      S_WRITE: state_d = last_word ? S_DONE : S_LO;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Whether the upcoming state accepts stream bytes.
  always_comb begin
    rx_next = 1'b0;
    case (state_d)
      S_HDR, S_LO, S_HI: rx_next = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK:             rx_next = 1'b1;
`endif
      default:           rx_next = 1'b0;
    endcase
  end

  // State register plus status outputs registered from the next state so
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bus.in_ready <= 1'b0;
      bus.instr_we <= 1'b0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus.in_ready <= rx_next;
      bus.instr_we <= (state_d == S_WRITE);
      cpu_reset    <= (state_d != S_DONE);
      done         <= (state_d == S_DONE);
      error        <= (state_d == S_ERROR);
    end
  end

  // Word assembly, word counter and the registered memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q            <= '0;
      cnt_q          <= '0;
      lo_q           <= '0;
      bus.instr_out  <= '0;
      bus.instr_addr <= '0;
    end else begin
      if (start_go)
        cnt_q <= '0;
      // A good header never exceeds DEPTH, so it fits the counter width.
      if (state_q == S_HDR && xfer && !hdr_bad)
        n_q <= bus.in_data[CW-1:0];
      if (state_q == S_LO && xfer)
        lo_q <= bus.in_data;
      // A malformed high byte must not disturb the write port.
      if (state_q == S_HI && xfer && !hi_bad) begin
        bus.instr_out  <= {bus.in_data[HW-1:0], lo_q};
        bus.instr_addr <= cnt_q[ADDR_W-1:0];
      end
      if (state_q == S_WRITE && !last_word)
        cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of header and data bytes, restarted with each load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sum_q <= '0;
    else if (start_go)
      sum_q <= '0;
    else if (xfer && (state_q == S_HDR || state_q == S_LO || state_q == S_HI))
      sum_q <= sum_q + bus.in_data;
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frames checked against a frame-level model
// of the loader (which words land where, and whether the load ends in done
// or error).
module tb_program_loader;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [3:0]  a;
    logic [12:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, done, error;

  program_loader_if #(.INSTR_W(13), .ADDR_W(4)) bus ();

  program_loader #(.INSTR_W(13), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errs    = 0;
  logic [7:0] frame[$];
  wr_t  exp_q[$];
  wr_t  got_q[$];
  int   n_acc;
  bit   exp_err;

  // Capture every memory write, sampled mid-cycle.
  always @(negedge clk)
    if (!reset && bus.instr_we === 1'b1)
      got_q.push_back('{a: bus.instr_addr, d: bus.instr_out});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level model: how many bytes get accepted, which words are written,
  // and whether the load ends in error.
  task automatic model();
    int n;
    logic [7:0] s, lo, hi;
    exp_q.delete();
    exp_err = 1'b0;
    n_acc   = 1;
    n       = int'(frame[0]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    s = frame[0];
    for (int i = 0; i < n; i++) begin
      lo = frame[1 + 2*i];
      hi = frame[2 + 2*i];
      n_acc += 2;
      if (hi > 8'd31) begin
        exp_err = 1'b1;
        return;
      end
      exp_q.push_back('{a: 4'(i), d: {hi[4:0], lo}});
      s = s + lo + hi;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    n_acc += 1;
    if (frame[1 + 2*n] != s) exp_err = 1'b1;
`endif
  endtask

  // Append the checksum byte (when the feature is built in), offset by off.
  task automatic add_ck(input logic [7:0] off);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] s = 8'd0;
    foreach (frame[i]) s = s + frame[i];
    frame.push_back(s + off);
`else
    if (off != 8'd0) frame.push_back(8'd0); // trailing byte is never consumed
`endif
  endtask

  task automatic build_frame(input int n, input int bad_word);
    logic [7:0] hi;
    frame.delete();
    frame.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      frame.push_back(8'($urandom));
      hi = {3'b000, 5'($urandom)};
      if (i == bad_word) hi[7:5] = 3'($urandom_range(7, 1));
      frame.push_back(hi);
    end
    add_ck(8'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int pct);
    bit v, ok;
    ok = 1'b0;
    for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
      @(negedge clk);
      v = ($urandom_range(99) >= pct);
      bus.in_valid = v;
      bus.in_data  = v ? b : 8'($urandom);
      if (v && bus.in_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk);
      end
    end
    if (!ok) begin
      vectors++; errs++;
      $display("FAIL send_byte timeout: byte %02h never accepted", b);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input string name);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s start in_ready: got %b want 1", name, bus.in_ready); end
    vectors++; if (cpu_reset !== 1'b1) begin errs++; $display("FAIL %s start cpu_reset: got %b want 1", name, cpu_reset); end
    vectors++; if (done !== 1'b0) begin errs++; $display("FAIL %s start done: got %b want 0", name, done); end
    vectors++; if (error !== 1'b0) begin errs++; $display("FAIL %s start error: got %b want 0", name, error); end
  endtask

  task automatic check_writes(input string name);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL %s write count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          errs++;
          $display("FAIL %s write %0d: got a=%0d d=%04h want a=%0d d=%04h",
                   name, i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
    end
  endtask

  // Load the global frame with stalls; optional 20-cycle gap before byte
  // gap_at, during which start may be pulsed (it must be ignored).
  task automatic run_frame(input string name, input int pct, input int gap_at,
                           input bit poke);
    bit fin;
    model();
    got_q.delete();
    pulse_start(name);
    for (int i = 0; i < n_acc; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 20; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          start = poke && (g == 10);
        end
        start = 1'b0;
      end
      send_byte(frame[i], pct);
    end
    drop_valid();
    fin = 1'b0;
    for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
      if (done === 1'b1 || error === 1'b1) fin = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!fin) begin errs++; $display("FAIL %s outcome timeout: done=%b error=%b", name, done, error); end
    vectors++; if (done !== !exp_err) begin errs++; $display("FAIL %s done: got %b want %b", name, done, !exp_err); end
    vectors++; if (error !== exp_err) begin errs++; $display("FAIL %s error: got %b want %b", name, error, exp_err); end
    vectors++; if (cpu_reset !== exp_err) begin errs++; $display("FAIL %s cpu_reset: got %b want %b", name, cpu_reset, exp_err); end
    vectors++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL %s in_ready at end: got %b want 0", name, bus.in_ready); end
    check_writes(name);
  endtask

  task automatic check_reset_vals(input string name);
    vectors++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL %s in_ready: got %b want 0", name, bus.in_ready); end
    vectors++; if (bus.instr_we !== 1'b0) begin errs++; $display("FAIL %s instr_we: got %b want 0", name, bus.instr_we); end
    vectors++; if (bus.instr_out !== 13'd0) begin errs++; $display("FAIL %s instr_out: got %04h want 0000", name, bus.instr_out); end
    vectors++; if (bus.instr_addr !== 4'd0) begin errs++; $display("FAIL %s instr_addr: got %0d want 0", name, bus.instr_addr); end
    vectors++; if (cpu_reset !== 1'b1) begin errs++; $display("FAIL %s cpu_reset: got %b want 1", name, cpu_reset); end
    vectors++; if (done !== 1'b0) begin errs++; $display("FAIL %s done: got %b want 0", name, done); end
    vectors++; if (error !== 1'b0) begin errs++; $display("FAIL %s error: got %b want 0", name, error); end
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals(name);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(negedge clk);
    async_reset("reset");
  endtask

  task automatic test_normal();
    logic [12:0] want[3] = '{13'h0800, 13'h0891, 13'h0914};
    frame = '{8'h03, 8'h00, 8'h08, 8'h91, 8'h08, 8'h14, 8'h09};
    add_ck(8'd0);
    run_frame("normal", 0, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got_q.size() <= i || got_q[i] !== {4'(i), want[i]}) begin
        errs++;
        $display("FAIL normal fixed word %0d: got %05h want a=%0d d=%04h", i,
                 (got_q.size() > i) ? got_q[i] : '0, i, want[i]);
      end
    end
  endtask

  task automatic test_bad_header();
    frame = '{8'h00};
    run_frame("hdr00", 0, -1, 1'b0);
    frame = '{8'h11};
    run_frame("hdr11", 0, -1, 1'b0);
    frame = '{8'($urandom_range(255, 17))};
    run_frame("hdr_big", 0, -1, 1'b0);
  endtask

  task automatic test_bad_high();
    frame = '{8'h01, 8'h00, 8'h28};
    run_frame("bad_hi", 0, -1, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    frame = '{8'h03, 8'h00, 8'h08, 8'h91, 8'h08, 8'h14, 8'h09};
    add_ck(8'd1);
    run_frame("bad_ck", 0, -1, 1'b0);
`endif
  endtask

  task automatic test_stall();
    build_frame(6, -1);
    run_frame("stall", 50, 4, 1'b1);
  endtask

  task automatic test_reset_midload();
    build_frame(5, -1);
    model();
    got_q.delete();
    pulse_start("midload");
    for (int i = 0; i < 5; i++) send_byte(frame[i], 30);
    drop_valid();
    repeat (2) @(negedge clk);
    exp_q = exp_q[0:1];
    check_writes("midload partial");
    async_reset("midload reset");
    build_frame(3, -1);
    run_frame("reload", 20, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, bad;
    for (int k = 0; k < 10; k++) begin
      n   = $urandom_range(DEPTH, 1);
      bad = ($urandom_range(99) < 20) ? $urandom_range(n - 1, 0) : -1;
      build_frame(n, bad);
      run_frame("random", $urandom_range(60, 0), -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_header();
    test_bad_high();
    test_stall();
    test_reset_midload();
    test_back_to_back();
    test_normal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
